// File: rtl/config_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module : config_chain_pkg
// Brief  : Shared state encoding and default parameter values for the
//          configuration-chain load controller.
// Rev    : 1.0  initial release
// ============================================================================
package config_chain_pkg;

  // Default generics for a production-sized configuration chain
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_TIMEOUT   = 256;

  // Controller state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_WORD = 3'd1;
  localparam state_t ST_SHIFT     = 3'd2;
  localparam state_t ST_DONE      = 3'd3;
  localparam state_t ST_ERROR     = 3'd4;

endpackage : config_chain_pkg
`default_nettype wire

// File: rtl/cfg_word_serializer.sv
`default_nettype none
// ============================================================================
// Module : cfg_word_serializer
// Brief  : Parallel-to-serial converter for one configuration word, LSB
//          first, with a bit-position counter that flags the final bit.
// Ports  : clk      - clock
//          rst      - synchronous clear of register and bit counter
//          load     - capture data and restart the bit counter
//          shift    - shift right one position and advance the counter
//          data     - configuration word to serialise
//          bit_out  - current serial bit (register LSB)
//          last_bit - current bit is the last bit of the word
// Rev    : 1.0  initial release
// ============================================================================
module cfg_word_serializer
  import config_chain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int WB_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [WB_W-1:0]   word_bit_q, word_bit_d;

  assign bit_out  = sr_q[0];
  assign last_bit = (word_bit_q == WB_W'(DATA_W - 1));

  always_comb begin
    sr_d       = sr_q;
    word_bit_d = word_bit_q;
    if (load) begin
      sr_d       = data;
      word_bit_d = '0;
    end else if (shift) begin
      sr_d       = sr_q >> 1;
      // Explicit wrap so non-power-of-two word widths restart cleanly
      word_bit_d = last_bit ? '0 : word_bit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      word_bit_q <= '0;
    end else begin
      sr_q       <= sr_d;
      word_bit_q <= word_bit_d;
    end
  end

endmodule : cfg_word_serializer
`default_nettype wire

// File: rtl/config_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module : config_chain_ctrl
// Brief  : Loads a serial configuration chain from a stream of parallel
//          words. Each accepted word is shifted out LSB first; the load ends
//          after CHAIN_LEN bits, and a word that does not arrive within
//          TIMEOUT cycles ends the load with an error.
// Ports  : prog_clk  - clock               pReset    - sync active-high reset
//          start     - begin a load        abort     - cancel the load
//          cfg_data  - configuration word  cfg_valid - cfg_data valid
//          cfg_ready - word accepted       ccff_head - serial bit to chain
//          chain_en  - chain shift enable  ccff_tail - chain tail (unused)
//          busy      - load in progress    done      - load completed
//          error     - word timeout
// Rev    : 1.0  initial release
// ============================================================================
module config_chain_ctrl
  import config_chain_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra count of headroom so bit_cnt can reach CHAIN_LEN without wrap
  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state_q, state_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TM_W-1:0] timer_q, timer_d;

  logic start_go;
  logic handshake;
  logic ser_rst;
  logic ser_bit;
  logic ser_last;
  logic unused_tail;

  // The chain tail is not observed by this controller
  assign unused_tail = ccff_tail;

  assign start_go  = start & ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERROR));
  assign handshake = cfg_valid & (state_q == ST_WAIT_WORD);
  // A fresh load always starts from word bit 0
  assign ser_rst   = pReset | start_go;

  cfg_word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk      (prog_clk),
    .rst      (ser_rst),
    .load     (handshake & ~abort),
    .shift    (state_q == ST_SHIFT),
    .data     (cfg_data),
    .bit_out  (ser_bit),
    .last_bit (ser_last)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_WAIT_WORD;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end
      ST_WAIT_WORD: begin
        if (cfg_valid) begin
          state_d = ST_SHIFT;
          timer_d = '0;
        end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        // Chain full wins over end-of-word: spare bits of the last word drop
        if (bit_cnt_q == BC_W'(CHAIN_LEN - 1)) begin
          state_d = ST_DONE;
        end else if (ser_last) begin
          state_d = ST_WAIT_WORD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
    end
  end

  // All outputs are decodes of registered state only
  assign cfg_ready = (state_q == ST_WAIT_WORD);
  assign chain_en  = (state_q == ST_SHIFT);
  assign ccff_head = (state_q == ST_SHIFT) & ser_bit;
  assign busy      = (state_q == ST_WAIT_WORD) || (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);

endmodule : config_chain_ctrl
`default_nettype wire

// File: tb/tb_config_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_config_chain_ctrl
// Brief  : Directed self-checking bench for config_chain_ctrl with
//          DATA_W=8, CHAIN_LEN=20, TIMEOUT=16. Inputs change and outputs
//          are sampled on the falling clock edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_config_chain_ctrl;

  localparam int DATA_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int TIMEOUT   = 16;

  logic              prog_clk  = 1'b0;
  logic              pReset    = 1'b1;
  logic              start     = 1'b0;
  logic              abort     = 1'b0;
  logic [DATA_W-1:0] cfg_data  = '0;
  logic              cfg_valid = 1'b0;
  logic              ccff_tail = 1'b0;
  logic              cfg_ready, ccff_head, chain_en, busy, done, error;

  always #5 prog_clk = ~prog_clk;

  config_chain_ctrl #(
    .DATA_W    (DATA_W),
    .CHAIN_LEN (CHAIN_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .ccff_head (ccff_head),
    .chain_en  (chain_en),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Words supplied for every load; expected serial stream is the low 20 bits
  // of {0x0F, 0x3C, 0xA5} taken LSB first, i.e. 20'hF3CA5.
  logic [7:0]  words [3] = '{8'hA5, 8'h3C, 8'h0F};
  localparam logic [19:0] EXP_STREAM = 20'hF3CA5;

  // Load observation state
  int          hs, nbits, idx, nburst, cur_run, lat_err, rdy_err;
  int          bursts [4];
  logic [19:0] cap;
  bit          hold_valid, pend_hs, seen_done;

  task automatic load_init();
    hs = 0; nbits = 0; idx = 0; nburst = 0; cur_run = 0;
    lat_err = 0; rdy_err = 0; cap = '0; pend_hs = 1'b0; seen_done = 1'b0;
    for (int i = 0; i < 4; i++) bursts[i] = 0;
  endtask

  // Called on a falling edge. Samples, drives, advances one cycle; returns
  // when done is seen, when nbits reaches stop_at, or after a cycle budget.
  task automatic load_run(input int stop_at, input int start_at);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pend_hs && !chain_en) lat_err++;
      if (chain_en) begin
        if (cfg_ready) rdy_err++;
        if (nbits < 20) cap[nbits] = ccff_head;
        nbits++;
        cur_run++;
      end else if (cur_run > 0) begin
        if (nburst < 4) bursts[nburst] = cur_run;
        nburst++;
        cur_run = 0;
      end
      if (done) begin
        seen_done = 1'b1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        break;
      end
      if (nbits == stop_at) begin
        cfg_valid = 1'b0;
        start     = 1'b0;
        break;
      end
      if (cfg_ready && idx < 3) begin
        cfg_valid = 1'b1;
        cfg_data  = words[idx];
        idx++;
      end else if (hold_valid) begin
        cfg_valid = 1'b1;
        cfg_data  = (idx < 3) ? words[idx] : 8'hEE;
      end else begin
        cfg_valid = 1'b0;
      end
      start   = (start_at >= 0) && (nbits == start_at) && chain_en;
      pend_hs = cfg_ready && cfg_valid;
      if (pend_hs) hs++;
      @(negedge prog_clk);
    end
  endtask

  task automatic expect_full_load(input string tag);
    n_total++; if (seen_done !== 1'b1) $display("FAIL %s_done_seen: got %b want 1", tag, seen_done); else n_pass++;
    n_total++; if (nbits != 20) $display("FAIL %s_bit_count: got %0d want 20", tag, nbits); else n_pass++;
    n_total++; if (nburst != 3) $display("FAIL %s_burst_count: got %0d want 3", tag, nburst); else n_pass++;
    n_total++; if (bursts[0] != 8 || bursts[1] != 8 || bursts[2] != 4)
      $display("FAIL %s_burst_len: got %0d,%0d,%0d want 8,8,4", tag, bursts[0], bursts[1], bursts[2]); else n_pass++;
    n_total++; if (cap !== EXP_STREAM) $display("FAIL %s_stream: got %h want %h", tag, cap, EXP_STREAM); else n_pass++;
    n_total++; if (hs != 3) $display("FAIL %s_handshakes: got %0d want 3", tag, hs); else n_pass++;
    n_total++; if (lat_err != 0) $display("FAIL %s_hs_latency: got %0d late bursts want 0", tag, lat_err); else n_pass++;
    n_total++; if (rdy_err != 0) $display("FAIL %s_ready_in_shift: got %0d cycles want 0", tag, rdy_err); else n_pass++;
    n_total++; if ({done, busy, chain_en, cfg_ready, error} !== 5'b10000)
      $display("FAIL %s_end_flags: got done,busy,en,rdy,err=%b want 10000", tag, {done, busy, chain_en, cfg_ready, error}); else n_pass++;
  endtask

  task automatic test_reset();
    pReset = 1'b1;
    repeat (2) @(negedge prog_clk);
    n_total++; if ({cfg_ready, ccff_head, chain_en, busy, done, error} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {cfg_ready, ccff_head, chain_en, busy, done, error}); else n_pass++;
    pReset = 1'b0;
    @(negedge prog_clk);
    n_total++; if ({cfg_ready, ccff_head, chain_en, busy, done, error} !== 6'b0)
      $display("FAIL idle_outputs: got %b want 000000", {cfg_ready, ccff_head, chain_en, busy, done, error}); else n_pass++;
  endtask

  task automatic test_normal_load();
    hold_valid = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    n_total++; if ({cfg_ready, busy} !== 2'b11) $display("FAIL start_to_ready: got rdy,busy=%b want 11", {cfg_ready, busy}); else n_pass++;
    load_init();
    load_run(-1, -1);
    expect_full_load("normal");
    repeat (3) @(negedge prog_clk);
    n_total++; if ({done, busy} !== 2'b10) $display("FAIL done_hold: got done,busy=%b want 10", {done, busy}); else n_pass++;
  endtask

  task automatic test_restart();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    n_total++; if ({done, cfg_ready} !== 2'b01) $display("FAIL restart_flags: got done,rdy=%b want 01", {done, cfg_ready}); else n_pass++;
    load_init();
    load_run(-1, -1);
    expect_full_load("restart");
  endtask

  // cfg_valid held high throughout; a start pulse mid-shift must be ignored
  task automatic test_back_to_back();
    hold_valid = 1'b1;
    cfg_valid  = 1'b1;
    cfg_data   = words[0];
    start      = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    load_init();
    load_run(-1, 10);
    hold_valid = 1'b0;
    expect_full_load("b2b");
  endtask

  task automatic test_timeout();
    int n_wait;
    int n_en;
    n_wait = 0;
    n_en   = 0;
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    while (cfg_ready && n_wait < 100) begin
      if (chain_en) n_en++;
      n_wait++;
      @(negedge prog_clk);
    end
    if (chain_en) n_en++;
    n_total++; if (n_wait != TIMEOUT) $display("FAIL timeout_wait_cycles: got %0d want %0d", n_wait, TIMEOUT); else n_pass++;
    n_total++; if ({error, busy, done} !== 3'b100) $display("FAIL timeout_flags: got err,busy,done=%b want 100", {error, busy, done}); else n_pass++;
    n_total++; if (n_en != 0) $display("FAIL timeout_chain_en: got %0d cycles want 0", n_en); else n_pass++;
    repeat (2) @(negedge prog_clk);
    n_total++; if (error !== 1'b1) $display("FAIL error_hold: got %b want 1", error); else n_pass++;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    n_total++; if ({error, cfg_ready} !== 2'b01) $display("FAIL error_restart: got err,rdy=%b want 01", {error, cfg_ready}); else n_pass++;
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    n_total++; if ({busy, cfg_ready} !== 2'b00) $display("FAIL abort_in_wait: got busy,rdy=%b want 00", {busy, cfg_ready}); else n_pass++;
  endtask

  // Abort at the 5th bit of word 2 (13th shifted bit overall)
  task automatic test_abort();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    load_init();
    load_run(13, -1);
    n_total++; if (nbits != 13) $display("FAIL abort_reach_bit: got %0d want 13", nbits); else n_pass++;
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    n_total++; if ({chain_en, busy, done, error, cfg_ready} !== 5'b0)
      $display("FAIL abort_next_cycle: got en,busy,done,err,rdy=%b want 00000", {chain_en, busy, done, error, cfg_ready}); else n_pass++;
    repeat (2) @(negedge prog_clk);
    n_total++; if ({chain_en, busy, cfg_ready} !== 3'b0)
      $display("FAIL abort_stays_idle: got en,busy,rdy=%b want 000", {chain_en, busy, cfg_ready}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset while waiting for a word
    start = 1'b1;
    @(negedge prog_clk);
    start  = 1'b0;
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    n_total++; if ({cfg_ready, ccff_head, chain_en, busy, done, error} !== 6'b0)
      $display("FAIL reset_in_wait: got %b want 000000", {cfg_ready, ccff_head, chain_en, busy, done, error}); else n_pass++;
    // Reset while shifting
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    load_init();
    load_run(10, -1);
    n_total++; if (nbits != 10) $display("FAIL reset_reach_bit: got %0d want 10", nbits); else n_pass++;
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    n_total++; if ({cfg_ready, ccff_head, chain_en, busy, done, error} !== 6'b0)
      $display("FAIL reset_in_shift: got %b want 000000", {cfg_ready, ccff_head, chain_en, busy, done, error}); else n_pass++;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    load_init();
    load_run(-1, -1);
    expect_full_load("after_reset");
  endtask

  initial begin
    hold_valid = 1'b0;
    load_init();
    test_reset();
    test_normal_load();
    test_restart();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_config_chain_ctrl
`default_nettype wire
